// File: rtl/div_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_unit_pkg
// Shared definitions for the MIPS execute-stage divider: machine word width
// and the divider FSM state encoding.
// -----------------------------------------------------------------------------
package div_unit_pkg;

    // Architectural word width, also used by the HI/LO register file and EX.
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        DIV_IDLE    = 2'b00,
        DIV_DIVZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

endpackage : div_unit_pkg

// File: rtl/div_unit_step.sv
// -----------------------------------------------------------------------------
// div_unit_step
// One restoring-division iteration: shift the partial remainder left by one,
// compare the upper half against the divisor, subtract when it fits and
// shift the resulting quotient bit into the LSB.
//
// Ports:
//   part_i     [2*WIDTH-1:0]  {remainder, dividend/quotient} before the step
//   divisor_i  [WIDTH-1:0]    divisor magnitude
//   part_o     [2*WIDTH-1:0]  {remainder, dividend/quotient} after the step
// -----------------------------------------------------------------------------
module div_unit_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] part_i,
    input  logic [WIDTH-1:0]   divisor_i,
    output logic [2*WIDTH-1:0] part_o
);

    // The shifted value is 2*WIDTH+1 bits wide: the bit shifted out of the
    // remainder takes part in the compare. The stored remainder never needs
    // that bit, because after the step it is always below the divisor.
    logic [2*WIDTH:0] wide;
    logic [WIDTH:0]   upper;

    // NOTE: every output of a combinational block is assigned on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        wide   = {part_i, 1'b0};
        upper  = wide[2*WIDTH:WIDTH];
        part_o = wide[2*WIDTH-1:0];
        if (upper >= {1'b0, divisor_i}) begin
            // Difference is below the divisor, so WIDTH bits hold it exactly.
            part_o = {upper[WIDTH-1:0] - divisor_i, wide[WIDTH-1:1], 1'b1};
        end
    end

endmodule : div_unit_step

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Multi-cycle integer divider serving DIV / DIVU in the execute stage.
// Quotient goes to LO, remainder to HI, both written in a single END cycle.
// Signed operations divide magnitudes and fix the signs up at the end.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               divide request, only taken in IDLE
//   signed_op           1 = DIV, 0 = DIVU
//   dividend, divisor   rs / rt operands, sampled with start
//   cancel              pipeline flush, returns to IDLE without writing
//   stall_req           hold request to the pipeline
//   hi_we / hi_i        HI write pulse and remainder
//   lo_we / lo_i        LO write pulse and quotient
// -----------------------------------------------------------------------------
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             stall_req,
    output logic             hi_we,
    output logic [WIDTH-1:0] hi_i,
    output logic             lo_we,
    output logic [WIDTH-1:0] lo_i
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   count_q;
    logic [2*WIDTH-1:0] part_q;        // {remainder, dividend -> quotient}
    logic [2*WIDTH-1:0] part_step;
    logic [WIDTH-1:0]   divisor_q;
    logic               neg_quot_q;
    logic               neg_rem_q;

    logic [WIDTH-1:0]   dividend_abs;
    logic [WIDTH-1:0]   divisor_abs;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    // Magnitudes are only taken for DIV; DIVU operands pass through as-is.
    // The most negative value maps onto itself, which is its correct
    // unsigned magnitude.
    assign dividend_abs = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
    assign divisor_abs  = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;

    assign quot = part_q[WIDTH-1:0];
    assign rem  = part_q[2*WIDTH-1:WIDTH];

    div_unit_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .part_i    (part_q),
        .divisor_i (divisor_q),
        .part_o    (part_step)
    );

    // ---------------------------------------------------------------- state
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    state_d = (divisor == '0) ? DIV_DIVZERO : DIV_ON;
                end
            end
            DIV_DIVZERO: state_d = DIV_END;
            DIV_ON: begin
                if (count_q == CNT_LAST) begin
                    state_d = DIV_END;
                end
            end
            DIV_END: state_d = DIV_IDLE;
            default: state_d = DIV_IDLE;
        endcase
        // A flush overrides whatever the FSM would do.
        if (cancel) begin
            state_d = DIV_IDLE;
        end
    end

    // -------------------------------------------------------------- counter
    always_ff @(posedge clk) begin
        if (rst || state_q != DIV_ON) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    // ------------------------------------------------------------- datapath
    // NOTE: the datapath registers carry no reset; their contents are only
    // observed in END, which is always preceded by a fresh load in IDLE.
    always_ff @(posedge clk) begin
        if (state_q == DIV_IDLE && start) begin
            if (divisor == '0) begin
                // Divide by zero: quotient all ones, remainder the raw dividend.
                part_q     <= {dividend, {WIDTH{1'b1}}};
                divisor_q  <= divisor;
                neg_quot_q <= 1'b0;
                neg_rem_q  <= 1'b0;
            end else begin
                part_q     <= {{WIDTH{1'b0}}, dividend_abs};
                divisor_q  <= divisor_abs;
                neg_quot_q <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                neg_rem_q  <= signed_op & dividend[WIDTH-1];
            end
        end else if (state_q == DIV_ON) begin
            part_q <= part_step;
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        stall_req = 1'b0;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        hi_i      = '0;
        lo_i      = '0;
        unique case (state_q)
            DIV_IDLE:    stall_req = start & ~cancel;
            DIV_DIVZERO: stall_req = 1'b1;
            DIV_ON:      stall_req = 1'b1;
            DIV_END: begin
                // Stall drops here so the stage advances as the write lands.
                hi_we = ~cancel;
                lo_we = ~cancel;
                hi_i  = neg_rem_q  ? -rem  : rem;
                lo_i  = neg_quot_q ? -quot : quot;
            end
            default: ;
        endcase
    end

endmodule : div_unit

// File: doc/div_unit.md
Name: div_unit

Overview:
Multi-cycle 32-bit integer divider for the MIPS execute stage. It serves DIV and DIVU, and drives the HI/LO register write port (hi_we/hi_i/lo_we/lo_i).
- Quotient is written to LO; remainder is written to HI.
- While busy, it holds the pipeline via stall_req.

Parameters:
- WIDTH, 32: operand, quotient and remainder width. Iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a divide; sampled only in IDLE.
- signed_op  input  1  1 = DIV (two's complement), 0 = DIVU.
- dividend  input  WIDTH  rs operand, sampled with start.
- divisor  input  WIDTH  rt operand, sampled with start.
- cancel  input  1  flush from exception/branch; aborts the operation.
- stall_req  output  1  pipeline hold request.
- hi_we  output  1  HI write enable, one-cycle pulse.
- hi_i  output  WIDTH  remainder, valid when hi_we=1.
- lo_we  output  1  LO write enable, one-cycle pulse.
- lo_i  output  WIDTH  quotient, valid when lo_we=1.

Behaviour:
- Reset (rst=1 at posedge):
  - State goes to IDLE and the counter clears.
  - hi_we=lo_we=0, hi_i=lo_i=0, stall_req=0.
  - Reset mid-operation discards the result; no write occurs.
- States: IDLE, DIVZERO, ON, END.
- IDLE:
  - start=1 and divisor!=0 → latch |dividend|, |divisor|, sign_q = signed_op & (a[31]^b[31]), sign_r = signed_op & a[31]; go to ON with count=0.
  - start=1 and divisor==0 → go to DIVZERO.
  - Absolute value is taken only when signed_op=1.
- ON:
  - One restoring shift-subtract step per cycle on a 2*WIDTH+1-bit partial remainder.
  - The quotient bit shifts in at the LSB; count increments.
  - When count==WIDTH-1 the step completes and the state goes to END.
  - Exactly WIDTH cycles in ON.
- DIVZERO: one cycle, then END with quotient = all ones and remainder = dividend as sampled.
- END:
  - hi_we=lo_we=1 for exactly this cycle.
  - lo_i = sign_q ? -q : q; hi_i = sign_r ? -r : r.
  - Next state is IDLE.
- Outputs outside END: hi_we=lo_we=0 and hi_i=lo_i=0.
- Latency for start accepted at cycle T:
  - Normal divide: ON T+1..T+32, END at T+33.
  - Divide by zero: DIVZERO at T+1, END at T+2.
- stall_req:
  - Combinational: (IDLE & start & ~cancel) | DIVZERO | ON.
  - Low in END, so the stage advances in the same cycle the write lands.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0. This falls out of unsigned magnitude arithmetic with wrap; no special case.
- Priority: rst > cancel > FSM.
  - cancel=1 in any state → next state IDLE, no write pulse.
  - cancel in END suppresses hi_we/lo_we combinationally.
- start while not IDLE is ignored; operands are not re-sampled.
- Operand changes after the start cycle have no effect.

Decomposition:
- Shared package/defines.vh holds:
  - state encodings (DIV_IDLE=2'b00, DIV_DIVZERO=2'b01, DIV_ON=2'b10, DIV_END=2'b11);
  - the 32-bit word width define, reused by hilo_reg and ex.
- One natural sub-module: div_step, a combinational single-iteration compare/subtract/shift instantiated once. The FSM, counter and sign fix-up stay in div_unit.

Test Plan:
- DIVU 100/7, start at T → stall_req=1 during T..T+32; at T+33 lo_i=14, hi_i=2, hi_we=lo_we=1; IDLE at T+34.
- DIV -7/2 (0xFFFFFFF9/0x00000002) → END at T+33 with lo_i=0xFFFFFFFD, hi_i=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF → lo_i=0x80000000, hi_i=0x00000000. DIVU 0xFFFFFFFF/1 → lo_i=0xFFFFFFFF, hi_i=0.
- DIVU 5/0 → DIVZERO at T+1; END at T+2 with lo_i=0xFFFFFFFF, hi_i=5; stall_req=1 only on T and T+1.
- cancel at T+10 → no hi_we/lo_we pulse ever, stall_req=0 from T+11. A new DIVU 9/3 at T+12 gives lo_i=3, hi_i=0 at T+45.
- rst=1 at T+20 mid-op → all outputs 0 next cycle, no write. Also: start pulsed at T+5 while in ON → ignored, result unchanged.
